// File: rtl/commit_unit_pkg.sv
// rtl/commit_unit_pkg.sv - widths, instr_id constants and state encoding for the commit stage
package commit_unit_pkg;
  localparam int INSTR_ID_W = 8;
  localparam int REG_IDX_W  = 5;
  localparam int ROB_IDX_W  = 4;
  localparam int LSB_IDX_W  = 4;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;

  localparam logic [INSTR_ID_W-1:0] HALT_ID_DEF     = 8'h00;
  localparam logic [INSTR_ID_W-1:0] STORE_ID_LO_DEF = 8'h18;
  localparam logic [INSTR_ID_W-1:0] STORE_ID_HI_DEF = 8'h1A;

  typedef enum logic [1:0] {
    CMT_RUN   = 2'd0,
    CMT_FLUSH = 2'd1,
    CMT_HALT  = 2'd2
  } cmt_state_e;
endpackage

// File: rtl/commit_classify.sv
// rtl/commit_classify.sv - decodes store and halt ops from a committed instr_id
module commit_classify
  import commit_unit_pkg::*;
#(
  parameter logic [INSTR_ID_W-1:0] HALT_ID     = HALT_ID_DEF,
  parameter logic [INSTR_ID_W-1:0] STORE_ID_LO = STORE_ID_LO_DEF,
  parameter logic [INSTR_ID_W-1:0] STORE_ID_HI = STORE_ID_HI_DEF
) (
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  output logic                  is_store,
  output logic                  is_halt
);
  assign is_store = (instr_id_in >= STORE_ID_LO) && (instr_id_in <= STORE_ID_HI);
  assign is_halt  = (instr_id_in == HALT_ID);
endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - retires ROB records: rf writeback, store release, flush/redirect, halt
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter logic [INSTR_ID_W-1:0] HALT_ID     = HALT_ID_DEF,
  parameter logic [INSTR_ID_W-1:0] STORE_ID_LO = STORE_ID_LO_DEF,
  parameter logic [INSTR_ID_W-1:0] STORE_ID_HI = STORE_ID_HI_DEF,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_commit_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [REG_IDX_W-1:0]  rd_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic [LSB_IDX_W-1:0]  lsb_pos_in,
  input  logic [WORD_W-1:0]     res_in,
  input  logic                  jump_en_in,
  input  logic [ADDR_W-1:0]     jump_a_in,
  output logic                  rf_we_out,
  output logic [REG_IDX_W-1:0]  rf_rd_out,
  output logic [WORD_W-1:0]     rf_data_out,
  output logic [ROB_IDX_W-1:0]  rf_rob_pos_out,
  output logic                  lsb_commit_en_out,
  output logic [LSB_IDX_W-1:0]  lsb_commit_pos_out,
  output logic                  clear_branch_out,
  output logic                  pc_redirect_en_out,
  output logic [ADDR_W-1:0]     pc_redirect_a_out,
  output logic                  halt_out,
  output logic [CNT_WIDTH-1:0]  retired_cnt_out
);
  cmt_state_e state_q, state_d;
  logic       accept, is_store, is_halt, rf_go, lsb_go, flush_go;

  commit_classify #(
    .HALT_ID     (HALT_ID),
    .STORE_ID_LO (STORE_ID_LO),
    .STORE_ID_HI (STORE_ID_HI)
  ) u_classify (
    .instr_id_in (instr_id_in),
    .is_store    (is_store),
    .is_halt     (is_halt)
  );

  // With rdy_in low nothing is accepted and the state holds, so the record is seen once later.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (rdy_in) begin
      case (state_q)
        CMT_RUN: begin
          if (rob_commit_en_in) begin
            accept = 1'b1;
            if (is_halt)         state_d = CMT_HALT;
            else if (jump_en_in) state_d = CMT_FLUSH;
          end
        end
        CMT_FLUSH: state_d = CMT_RUN;
        CMT_HALT:  state_d = CMT_HALT;
        default:   state_d = CMT_RUN;
      endcase
    end
  end

  assign rf_go    = accept && (rd_in != '0) && !is_store;
  assign lsb_go   = accept && is_store;
  assign flush_go = accept && jump_en_in && !is_halt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q            <= CMT_RUN;
      rf_we_out          <= 1'b0;
      rf_rd_out          <= '0;
      rf_data_out        <= '0;
      rf_rob_pos_out     <= '0;
      lsb_commit_en_out  <= 1'b0;
      lsb_commit_pos_out <= '0;
      clear_branch_out   <= 1'b0;
      pc_redirect_en_out <= 1'b0;
      pc_redirect_a_out  <= '0;
      halt_out           <= 1'b0;
      retired_cnt_out    <= '0;
    end else begin
      state_q            <= state_d;
      rf_we_out          <= rf_go;
      lsb_commit_en_out  <= lsb_go;
      clear_branch_out   <= flush_go;
      pc_redirect_en_out <= flush_go;
      if (rf_go) begin
        rf_rd_out      <= rd_in;
        rf_data_out    <= res_in;
        rf_rob_pos_out <= rob_pos_in;
      end
      if (lsb_go)   lsb_commit_pos_out <= lsb_pos_in;
      if (flush_go) pc_redirect_a_out  <= jump_a_in;
      if (accept && is_halt) halt_out <= 1'b1;
      if (accept) retired_cnt_out <= retired_cnt_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed vector bench for commit_unit
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  rdy_in;
  logic                  rob_commit_en_in;
  logic [INSTR_ID_W-1:0] instr_id_in;
  logic [REG_IDX_W-1:0]  rd_in;
  logic [ROB_IDX_W-1:0]  rob_pos_in;
  logic [LSB_IDX_W-1:0]  lsb_pos_in;
  logic [WORD_W-1:0]     res_in;
  logic                  jump_en_in;
  logic [ADDR_W-1:0]     jump_a_in;
  logic                  rf_we_out;
  logic [REG_IDX_W-1:0]  rf_rd_out;
  logic [WORD_W-1:0]     rf_data_out;
  logic [ROB_IDX_W-1:0]  rf_rob_pos_out;
  logic                  lsb_commit_en_out;
  logic [LSB_IDX_W-1:0]  lsb_commit_pos_out;
  logic                  clear_branch_out;
  logic                  pc_redirect_en_out;
  logic [ADDR_W-1:0]     pc_redirect_a_out;
  logic                  halt_out;
  logic [31:0]           retired_cnt_out;

  commit_unit dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .rob_commit_en_in   (rob_commit_en_in),
    .instr_id_in        (instr_id_in),
    .rd_in              (rd_in),
    .rob_pos_in         (rob_pos_in),
    .lsb_pos_in         (lsb_pos_in),
    .res_in             (res_in),
    .jump_en_in         (jump_en_in),
    .jump_a_in          (jump_a_in),
    .rf_we_out          (rf_we_out),
    .rf_rd_out          (rf_rd_out),
    .rf_data_out        (rf_data_out),
    .rf_rob_pos_out     (rf_rob_pos_out),
    .lsb_commit_en_out  (lsb_commit_en_out),
    .lsb_commit_pos_out (lsb_commit_pos_out),
    .clear_branch_out   (clear_branch_out),
    .pc_redirect_en_out (pc_redirect_en_out),
    .pc_redirect_a_out  (pc_redirect_a_out),
    .halt_out           (halt_out),
    .retired_cnt_out    (retired_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy, en;
    logic [7:0]  id;
    logic [4:0]  rd;
    logic [3:0]  rob, lsb;
    logic [31:0] res;
    logic        jmp;
    logic [31:0] ja;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [3:0]  e_rob;
    logic        e_lsb;
    logic [3:0]  e_lpos;
    logic        e_clr;
    logic [31:0] e_a;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(
    logic rdy, logic en, logic [7:0] id, logic [4:0] rd, logic [3:0] rob, logic [3:0] lsb,
    logic [31:0] res, logic jmp, logic [31:0] ja,
    logic e_we, logic [4:0] e_rd, logic [31:0] e_data, logic [3:0] e_rob,
    logic e_lsb, logic [3:0] e_lpos, logic e_clr, logic [31:0] e_a, logic e_halt, logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.en = en; v.id = id; v.rd = rd; v.rob = rob; v.lsb = lsb;
    v.res = res; v.jmp = jmp; v.ja = ja;
    v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data; v.e_rob = e_rob;
    v.e_lsb = e_lsb; v.e_lpos = e_lpos; v.e_clr = e_clr; v.e_a = e_a;
    v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " rf_we"},    64'(rf_we_out),          64'(v.e_we));
    chk({tag, " rf_rd"},    64'(rf_rd_out),          64'(v.e_rd));
    chk({tag, " rf_data"},  64'(rf_data_out),        64'(v.e_data));
    chk({tag, " rf_rob"},   64'(rf_rob_pos_out),     64'(v.e_rob));
    chk({tag, " lsb_en"},   64'(lsb_commit_en_out),  64'(v.e_lsb));
    chk({tag, " lsb_pos"},  64'(lsb_commit_pos_out), 64'(v.e_lpos));
    chk({tag, " clr"},      64'(clear_branch_out),   64'(v.e_clr));
    chk({tag, " redir_en"}, 64'(pc_redirect_en_out), 64'(v.e_clr));
    chk({tag, " redir_a"},  64'(pc_redirect_a_out),  64'(v.e_a));
    chk({tag, " halt"},     64'(halt_out),           64'(v.e_halt));
    chk({tag, " cnt"},      64'(retired_cnt_out),    64'(v.e_cnt));
  endtask

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; rob_commit_en_in = v.en; instr_id_in = v.id; rd_in = v.rd;
    rob_pos_in = v.rob; lsb_pos_in = v.lsb; res_in = v.res;
    jump_en_in = v.jmp; jump_a_in = v.ja;
  endtask

  initial begin
    vec_t z;
    // inputs                                          | expected outputs after the next edge
    //        rdy en  id     rd  rob  lsb res           j  ja      we rd  data          rob lsb lpos clr a       halt cnt
    vecs.push_back(mk(1, 0, 8'h05, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 8'h05, 3, 4, 0, 32'hDEADBEEF, 0, 32'h0,   1, 3, 32'hDEADBEEF, 4, 0, 0, 0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 8'h19, 7, 5, 2, 32'h55,       0, 32'h0,   0, 3, 32'hDEADBEEF, 4, 1, 2, 0, 32'h0,   0, 2));
    vecs.push_back(mk(1, 1, 8'h18, 0, 6, 3, 32'h0,        0, 32'h0,   0, 3, 32'hDEADBEEF, 4, 1, 3, 0, 32'h0,   0, 3));
    vecs.push_back(mk(1, 1, 8'h1A, 9, 6, 1, 32'h0,        0, 32'h0,   0, 3, 32'hDEADBEEF, 4, 1, 1, 0, 32'h0,   0, 4));
    vecs.push_back(mk(1, 1, 8'h1B, 2, 7, 5, 32'h11,       0, 32'h0,   1, 2, 32'h11,       7, 0, 1, 0, 32'h0,   0, 5));
    vecs.push_back(mk(1, 1, 8'h17, 0, 7, 5, 32'h12,       0, 32'h0,   0, 2, 32'h11,       7, 0, 1, 0, 32'h0,   0, 6));
    // mispredict, then a wrong-path record during FLUSH, then a normal record
    vecs.push_back(mk(1, 1, 8'h10, 1, 8, 0, 32'h104,      1, 32'h200, 1, 1, 32'h104,      8, 0, 1, 1, 32'h200, 0, 7));
    vecs.push_back(mk(1, 1, 8'h19, 9, 9, 6, 32'h999,      1, 32'h300, 0, 1, 32'h104,      8, 0, 1, 0, 32'h200, 0, 7));
    vecs.push_back(mk(1, 1, 8'h05, 4, 10, 0, 32'h44,      0, 32'h0,   1, 4, 32'h44,      10, 0, 1, 0, 32'h200, 0, 8));
    // stalled record held for three cycles, sampled once
    vecs.push_back(mk(0, 1, 8'h05, 5, 11, 0, 32'h55,      0, 32'h0,   0, 4, 32'h44,      10, 0, 1, 0, 32'h200, 0, 8));
    vecs.push_back(mk(0, 1, 8'h05, 5, 11, 0, 32'h55,      0, 32'h0,   0, 4, 32'h44,      10, 0, 1, 0, 32'h200, 0, 8));
    vecs.push_back(mk(0, 1, 8'h05, 5, 11, 0, 32'h55,      0, 32'h0,   0, 4, 32'h44,      10, 0, 1, 0, 32'h200, 0, 8));
    vecs.push_back(mk(1, 1, 8'h05, 5, 11, 0, 32'h55,      0, 32'h0,   1, 5, 32'h55,      11, 0, 1, 0, 32'h200, 0, 9));
    vecs.push_back(mk(1, 0, 8'h05, 5, 11, 0, 32'h55,      0, 32'h0,   0, 5, 32'h55,      11, 0, 1, 0, 32'h200, 0, 9));
    // halt with jump_en: halt wins, rf write still happens, no flush
    vecs.push_back(mk(1, 1, 8'h00, 6, 12, 0, 32'h66,      1, 32'h400, 1, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));
    vecs.push_back(mk(1, 1, 8'h05, 2, 13, 0, 32'h77,      0, 32'h0,   0, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));
    vecs.push_back(mk(1, 1, 8'h19, 2, 13, 7, 32'h77,      0, 32'h0,   0, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));
    vecs.push_back(mk(1, 1, 8'h10, 2, 13, 0, 32'h77,      1, 32'h500, 0, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));
    vecs.push_back(mk(1, 1, 8'h00, 2, 13, 0, 32'h77,      0, 32'h0,   0, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));
    vecs.push_back(mk(1, 1, 8'h05, 3, 14, 0, 32'h78,      0, 32'h0,   0, 6, 32'h66,      12, 0, 1, 0, 32'h200, 1, 10));

    z = mk(1, 0, 8'h05, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(z);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_all("reset", z);
    rst_in = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk_in);
      @(negedge clk_in);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // asynchronous reset in the middle of the flush cycle
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(mk(1, 1, 8'h10, 1, 2, 0, 32'h104, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_in);
    @(negedge clk_in);
    chk("pre_rst clr", 64'(clear_branch_out), 64'd1);
    drive(z);
    #2 rst_in = 1'b1;
    #1;
    chk_all("async_rst", z);
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(mk(1, 1, 8'h05, 3, 1, 0, 32'h77, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_in);
    @(negedge clk_in);
    chk_all("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h77, 1, 0, 0, 0, 32'h0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
